alu_pipe_stage: RTL

ALU_PIPE_STAGE -- requirements
Module: alu_pipe_stage

---
 rtl/alu_pipe_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_pipe_stage.sv
// Two-stage valid/ready pipeline around an external combinational ALU.
// S1 registers operands/control for the ALU; S2 captures result and flags.
module alu_pipe_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [4:0] out_flags,
    output logic [7:0] op_count
);

    logic       s1_valid_q, s1_valid_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_ctrl_q, alu_ctrl_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_result_q, out_result_d;
    logic [4:0] out_flags_q, out_flags_d;
    logic [7:0] op_count_q, op_count_d;

    logic s2_load;
    logic in_hs;
    logic out_hs;
    logic illegal;

    // S1 may refill in the same cycle it hands its contents to S2
    always_comb begin
        s2_load  = s1_valid_q & (~out_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_load;
        in_hs    = in_valid & in_ready;
        out_hs   = out_valid_q & out_ready;
        illegal  = (alu_ctrl_q > 4'b1011);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        if (in_hs) begin
            s1_valid_d = 1'b1;
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            alu_ctrl_d = in_op;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (s2_load) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_flags_d  = {illegal, alu_result[3], (alu_result == 4'd0),
                            alu_ovf, alu_carry};
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        op_count_d = op_count_q;
        if (out_hs) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_ctrl_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            out_result_q <= 4'd0;
            out_flags_q  <= 5'd0;
            op_count_q   <= 8'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign op_count   = op_count_q;

endmodule
